fifo_wr_arb: RTL and testbench



---
 rtl/fifo_wr_arb_pkg.sv | 38 +++
 rtl/fifo_wr_arb_rr_picker.sv | 41 ++++
 rtl/fifo_wr_arb.sv | 111 +++++++++++
 tb/tb_fifo_wr_arb.sv | 380 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_wr_arb_pkg.sv
// Shared types and the round-robin pick helper for fifo_wr_arb.
package fifo_wr_arb_pkg;

    localparam int unsigned MAX_REQ  = 16;
    localparam int unsigned MAX_ID_W = 4;

    typedef enum logic {
        IDLE = 1'b0,
        LOCK = 1'b1
    } arb_state_t;

    // First set bit of valid scanning ptr, ptr+1, ... modulo n_req; 0 when none is set.
    function automatic logic [MAX_ID_W-1:0] rr_pick(
        input logic [MAX_REQ-1:0]  valid,
        input logic [MAX_ID_W-1:0] ptr,
        input int unsigned         n_req
    );
        logic [MAX_ID_W-1:0] idx;
        logic                found;
        int unsigned         cand;
        idx   = '0;
        found = 1'b0;
        for (int unsigned i = 0; i < MAX_REQ; i++) begin
            if (i < n_req && !found) begin
                cand = 32'(ptr) + i;
                if (cand >= n_req) begin
                    cand = cand - n_req;
                end
                if (valid[MAX_ID_W'(cand)]) begin
                    idx   = MAX_ID_W'(cand);
                    found = 1'b1;
                end
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/fifo_wr_arb_rr_picker.sv
// Combinational round-robin picker: rotate valid by ptr, priority-encode, unrotate.
module rr_picker
    import fifo_wr_arb_pkg::*;
#(
    parameter int unsigned N_REQ = 4
) (
    input  logic [N_REQ-1:0]         valid,
    input  logic [$clog2(N_REQ)-1:0] ptr,
    output logic [$clog2(N_REQ)-1:0] pick_c,
    output logic                     any_valid_c
);

    localparam int unsigned ID_W = $clog2(N_REQ);

    logic [MAX_REQ-1:0]  rot;
    logic [MAX_ID_W-1:0] enc;
    int unsigned         src;
    int unsigned         unrot;

    always_comb begin
        rot   = '0;
        src   = 0;
        unrot = 0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            src = 32'(ptr) + i;
            if (src >= N_REQ) begin
                src = src - N_REQ;
            end
            rot[MAX_ID_W'(i)] = valid[ID_W'(src)];
        end
        // After rotation the highest priority sits at bit 0, so a plain scan from 0 suffices.
        enc   = rr_pick(rot, '0, N_REQ);
        unrot = 32'(enc) + 32'(ptr);
        if (unrot >= N_REQ) begin
            unrot = unrot - N_REQ;
        end
        pick_c      = ID_W'(unrot);
        any_valid_c = |valid;
    end

endmodule

// File: rtl/fifo_wr_arb.sv
// Round-robin, packet-locked arbiter for the single FIFO write port.
// Optional per-requester accepted-word counters under FIFO_WR_ARB_STATS_EN.
module fifo_wr_arb
    import fifo_wr_arb_pkg::*;
#(
    parameter int unsigned N_REQ      = 4,
    parameter int unsigned DATA_WIDTH = 8
`ifdef FIFO_WR_ARB_STATS_EN
    ,
    parameter int unsigned CNT_WIDTH  = 16
`endif
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [N_REQ-1:0]            req_valid,
    input  logic [N_REQ*DATA_WIDTH-1:0] req_data,
    input  logic [N_REQ-1:0]            req_last,
    output logic [N_REQ-1:0]            req_ready,
    output logic                        fifo_w_en,
    output logic [DATA_WIDTH-1:0]       fifo_data_in,
    input  logic                        fifo_full,
    output logic                        busy,
    output logic [$clog2(N_REQ)-1:0]    grant_id
`ifdef FIFO_WR_ARB_STATS_EN
    ,
    output logic [N_REQ*CNT_WIDTH-1:0]  stat_count
`endif
);

    localparam int unsigned ID_W = $clog2(N_REQ);

    arb_state_t      state;
    arb_state_t      state_d;
    logic [ID_W-1:0] ptr;
    logic [ID_W-1:0] ptr_d;
    logic [ID_W-1:0] grant_d;
    logic [ID_W-1:0] pick_c;
    logic            any_valid_c;
    logic            xfer_c;

    rr_picker #(
        .N_REQ (N_REQ)
    ) u_picker (
        .valid       (req_valid),
        .ptr         (ptr),
        .pick_c      (pick_c),
        .any_valid_c (any_valid_c)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            ptr      <= '0;
            grant_id <= '0;
        end else begin
            state    <= state_d;
            ptr      <= ptr_d;
            grant_id <= grant_d;
        end
    end

    // Owner keeps the port until its last word is accepted; ptr moves only at packet end.
    always_comb begin
        state_d   = state;
        ptr_d     = ptr;
        grant_d   = grant_id;
        req_ready = '0;
        xfer_c    = 1'b0;
        case (state)
            IDLE: begin
                if (any_valid_c) begin
                    grant_d = pick_c;
                    state_d = LOCK;
                end
            end
            LOCK: begin
                req_ready[grant_id] = ~fifo_full;
                xfer_c              = req_valid[grant_id] & ~fifo_full;
                if (xfer_c && req_last[grant_id]) begin
                    state_d = IDLE;
                    ptr_d   = (grant_id == ID_W'(N_REQ - 1)) ? '0 : grant_id + ID_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign fifo_w_en    = xfer_c;
    assign fifo_data_in = req_data[grant_id*DATA_WIDTH +: DATA_WIDTH];
    assign busy         = (state == LOCK);

`ifdef FIFO_WR_ARB_STATS_EN
    logic [CNT_WIDTH-1:0] cnt_q [N_REQ];

    // Counters wrap naturally at 2^CNT_WIDTH.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < int'(N_REQ); i++) begin
                cnt_q[i] <= '0;
            end
        end else if (xfer_c) begin
            cnt_q[grant_id] <= cnt_q[grant_id] + CNT_WIDTH'(1);
        end
    end

    for (genvar g = 0; g < int'(N_REQ); g++) begin : g_stat
        assign stat_count[g*CNT_WIDTH +: CNT_WIDTH] = cnt_q[g];
    end
`endif

endmodule

// File: tb/tb_fifo_wr_arb.sv
// Self-checking bench for fifo_wr_arb: directed scenarios plus a randomized run
// against a packet-level reference model. Stats checks compile with FIFO_WR_ARB_STATS_EN.
module tb_fifo_wr_arb;

    localparam int N     = 4;
    localparam int DW    = 8;
    localparam int DEPTH = 8;

    logic            clk;
    logic            rst;
    logic [N-1:0]    req_valid;
    logic [N*DW-1:0] req_data;
    logic [N-1:0]    req_last;
    logic [N-1:0]    req_ready;
    logic            fifo_w_en;
    logic [DW-1:0]   fifo_data_in;
    logic            fifo_full;
    logic            busy;
    logic [1:0]      grant_id;

    int n_tests = 0;
    int n_fail  = 0;
    logic [DW-1:0] fq[$];

`ifdef FIFO_WR_ARB_STATS_EN
    logic [N*16-1:0] stat_count;
    logic [N*4-1:0]  stat_count_w4;
    logic [N-1:0]    ready_w4;
    logic            w_en_w4;
    logic [DW-1:0]   data_w4;
    logic            busy_w4;
    logic [1:0]      gid_w4;
`endif

    fifo_wr_arb #(
        .N_REQ      (N),
        .DATA_WIDTH (DW)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_data     (req_data),
        .req_last     (req_last),
        .req_ready    (req_ready),
        .fifo_w_en    (fifo_w_en),
        .fifo_data_in (fifo_data_in),
        .fifo_full    (fifo_full),
        .busy         (busy),
        .grant_id     (grant_id)
`ifdef FIFO_WR_ARB_STATS_EN
        ,
        .stat_count   (stat_count)
`endif
    );

`ifdef FIFO_WR_ARB_STATS_EN
    fifo_wr_arb #(
        .N_REQ      (N),
        .DATA_WIDTH (DW),
        .CNT_WIDTH  (4)
    ) dut_w4 (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_data     (req_data),
        .req_last     (req_last),
        .req_ready    (ready_w4),
        .fifo_w_en    (w_en_w4),
        .fifo_data_in (data_w4),
        .fifo_full    (fifo_full),
        .busy         (busy_w4),
        .grant_id     (gid_w4),
        .stat_count   (stat_count_w4)
    );
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic idle_inputs();
        req_valid = '0;
        req_last  = '0;
        req_data  = '0;
        fifo_full = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        idle_inputs();
        fq.delete();
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        req_data = 32'hA5C3_7E11;
        #1;
        n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy: got %b need 0", busy); end
        n_tests++; if (fifo_w_en !== 1'b0) begin n_fail++; $display("FAIL rst_wen: got %b need 0", fifo_w_en); end
        n_tests++; if (req_ready !== 4'b0) begin n_fail++; $display("FAIL rst_ready: got %b need 0000", req_ready); end
        n_tests++; if (grant_id !== 2'd0) begin n_fail++; $display("FAIL rst_gid: got %0d need 0", grant_id); end
        n_tests++; if (fifo_data_in !== 8'h11) begin n_fail++; $display("FAIL rst_data: got %h need 11", fifo_data_in); end
        // requester 2 starts a 3-word packet, reset lands after its first word
        @(negedge clk);
        req_valid = 4'b0100; req_data = '0; req_data[23:16] = 8'h21;
        @(negedge clk); #1;
        n_tests++; if (grant_id !== 2'd2) begin n_fail++; $display("FAIL rst_pre_gid: got %0d need 2", grant_id); end
        n_tests++; if (fifo_w_en !== 1'b1) begin n_fail++; $display("FAIL rst_pre_wen: got %b need 1", fifo_w_en); end
        @(negedge clk);
        req_data[23:16] = 8'h22;
        rst = 1'b1;
        #1;
        n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_mid_busy: got %b need 0", busy); end
        n_tests++; if (fifo_w_en !== 1'b0) begin n_fail++; $display("FAIL rst_mid_wen: got %b need 0", fifo_w_en); end
        n_tests++; if (grant_id !== 2'd0) begin n_fail++; $display("FAIL rst_mid_gid: got %0d need 0", grant_id); end
        @(negedge clk);
        rst = 1'b0;
        req_valid = 4'b0101; req_last = 4'b0101;
        req_data = '0; req_data[7:0] = 8'h01; req_data[23:16] = 8'h21;
        @(negedge clk); #1;
        n_tests++; if (grant_id !== 2'd0) begin n_fail++; $display("FAIL rst_after_gid: got %0d need 0", grant_id); end
        n_tests++; if (busy !== 1'b1) begin n_fail++; $display("FAIL rst_after_busy: got %b need 1", busy); end
        n_tests++; if (fifo_data_in !== 8'h01) begin n_fail++; $display("FAIL rst_after_data: got %h need 01", fifo_data_in); end
        @(negedge clk);
        idle_inputs();
        #1;
        n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_after_idle: got %b need 0", busy); end
    endtask

    task automatic test_single();
        logic [7:0] w [3];
        int k = 0;
        int writes = 0;
        w[0] = 8'h11; w[1] = 8'h22; w[2] = 8'h33;
        for (int cyc = 0; cyc < 8; cyc++) begin
            @(negedge clk);
            req_valid = '0; req_last = '0; req_data = '0;
            if (k < 3) begin
                req_valid[1] = 1'b1;
                req_data[15:8] = w[k];
                req_last[1] = (k == 2);
            end
            #1;
            if (cyc == 1) begin
                n_tests++; if (grant_id !== 2'd1) begin n_fail++; $display("FAIL single_gid: got %0d need 1", grant_id); end
                n_tests++; if (busy !== 1'b1) begin n_fail++; $display("FAIL single_busy: got %b need 1", busy); end
            end
            if (fifo_w_en === 1'b1) begin
                if (writes < 3) begin
                    n_tests++; if (fifo_data_in !== w[writes]) begin n_fail++; $display("FAIL single_data: got %h need %h", fifo_data_in, w[writes]); end
                end
                n_tests++; if (cyc !== writes + 1) begin n_fail++; $display("FAIL single_cycle: write at cycle %0d need %0d", cyc, writes + 1); end
                writes++;
            end
            if (req_valid[1] && req_ready[1]) k++;
        end
        n_tests++; if (writes !== 3) begin n_fail++; $display("FAIL single_writes: got %0d need 3", writes); end
        n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL single_end_busy: got %b need 0", busy); end
        n_tests++; if (grant_id !== 2'd1) begin n_fail++; $display("FAIL single_hold_gid: got %0d need 1", grant_id); end
        // pointer should now favour requester 2 over 1 and 3
        @(negedge clk);
        req_valid = 4'b1110; req_last = 4'b1110;
        @(negedge clk); #1;
        n_tests++; if (grant_id !== 2'd2) begin n_fail++; $display("FAIL single_ptr: got %0d need 2", grant_id); end
        @(negedge clk);
        idle_inputs();
    endtask

    task automatic test_round_robin();
        int seq [N];
        int g;
        for (int i = 0; i < N; i++) seq[i] = 0;
        do_reset();
        for (int cyc = 0; cyc < 10; cyc++) begin
            @(negedge clk);
            req_valid = 4'b1111; req_last = 4'b1111;
            for (int i = 0; i < N; i++) req_data[i*DW +: DW] = 8'((i << 4) | seq[i]);
            #1;
            if (cyc % 2 == 0) begin
                n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rr_bubble: cycle %0d busy %b need 0", cyc, busy); end
            end else begin
                g = (cyc / 2) % N;
                n_tests++; if (grant_id !== 2'(g)) begin n_fail++; $display("FAIL rr_order: cycle %0d got %0d need %0d", cyc, grant_id, g); end
                n_tests++; if (req_ready !== 4'(1 << g)) begin n_fail++; $display("FAIL rr_ready: got %b need %b", req_ready, 4'(1 << g)); end
                n_tests++; if (fifo_data_in !== 8'((g << 4) | seq[g])) begin n_fail++; $display("FAIL rr_data: got %h need %h", fifo_data_in, 8'((g << 4) | seq[g])); end
            end
            for (int i = 0; i < N; i++) if (req_valid[i] && req_ready[i]) seq[i]++;
        end
        @(negedge clk);
        idle_inputs();
        #1;
`ifdef FIFO_WR_ARB_STATS_EN
        begin
            int exp_cnt [N];
            exp_cnt[0] = 2; exp_cnt[1] = 1; exp_cnt[2] = 1; exp_cnt[3] = 1;
            for (int i = 0; i < N; i++) begin
                n_tests++; if (stat_count[i*16 +: 16] !== 16'(exp_cnt[i])) begin n_fail++; $display("FAIL rr_stat%0d: got %0d need %0d", i, stat_count[i*16 +: 16], exp_cnt[i]); end
            end
        end
`endif
    endtask

    task automatic test_no_interleave();
        logic [7:0] wr[$];
        logic [7:0] exp_wr [6];
        int k3 = 0;
        bit got0 = 0;
        exp_wr[0] = 8'hD0; exp_wr[1] = 8'hD1; exp_wr[2] = 8'hD2;
        exp_wr[3] = 8'hD3; exp_wr[4] = 8'h01; exp_wr[5] = 8'hDE;
        do_reset();
        // one packet from requester 2 moves the pointer to 3
        @(negedge clk);
        req_valid = 4'b0100; req_last = 4'b0100; req_data[23:16] = 8'hC0;
        @(negedge clk);
        @(negedge clk);
        idle_inputs();
        for (int cyc = 0; cyc < 12; cyc++) begin
            @(negedge clk);
            req_valid = '0; req_last = '0; req_data = '0;
            req_valid[0] = !got0; req_last[0] = 1'b1; req_data[7:0] = 8'h01;
            req_valid[3] = (k3 < 5);
            req_data[31:24] = (k3 < 4) ? 8'(8'hD0 + k3) : 8'hDE;
            req_last[3] = (k3 >= 3);
            #1;
            if (cyc >= 1 && cyc <= 4) begin
                n_tests++; if (req_ready[0] !== 1'b0) begin n_fail++; $display("FAIL ni_ready0: cycle %0d got %b need 0", cyc, req_ready[0]); end
                n_tests++; if (fifo_w_en !== 1'b1) begin n_fail++; $display("FAIL ni_wen: cycle %0d got %b need 1", cyc, fifo_w_en); end
            end
            if (fifo_w_en === 1'b1) wr.push_back(fifo_data_in);
            if (req_valid[0] && req_ready[0]) got0 = 1;
            if (req_valid[3] && req_ready[3]) k3++;
        end
        n_tests++; if (wr.size() !== 6) begin n_fail++; $display("FAIL ni_count: got %0d need 6", wr.size()); end
        for (int i = 0; i < 6 && i < wr.size(); i++) begin
            n_tests++; if (wr[i] !== exp_wr[i]) begin n_fail++; $display("FAIL ni_seq%0d: got %h need %h", i, wr[i], exp_wr[i]); end
        end
        idle_inputs();
    endtask

    task automatic test_full_backpressure();
        int k = 0;
        int writes = 0;
        int reads = 0;
        logic [7:0] popped;
        do_reset();
        for (int cyc = 0; cyc < 24; cyc++) begin
            @(negedge clk);
            if (cyc >= 16 && reads < 2) begin
                popped = fq.pop_front();
                n_tests++; if (popped !== 8'(8'h40 + reads)) begin n_fail++; $display("FAIL bp_pop: got %h need %h", popped, 8'(8'h40 + reads)); end
                reads++;
            end
            fifo_full = (fq.size() >= DEPTH);
            req_valid[0] = (k < 10); req_data[7:0] = 8'(8'h40 + k); req_last[0] = (k == 9);
            #1;
            if (fifo_w_en === 1'b1) begin fq.push_back(fifo_data_in); writes++; end
            if (req_valid[0] && req_ready[0]) k++;
            if (cyc == 15) begin
                n_tests++; if (writes !== 8) begin n_fail++; $display("FAIL bp_writes_full: got %0d need 8", writes); end
                n_tests++; if (req_ready[0] !== 1'b0) begin n_fail++; $display("FAIL bp_ready: got %b need 0", req_ready[0]); end
                n_tests++; if (fifo_w_en !== 1'b0) begin n_fail++; $display("FAIL bp_wen: got %b need 0", fifo_w_en); end
                n_tests++; if (busy !== 1'b1) begin n_fail++; $display("FAIL bp_busy: got %b need 1", busy); end
            end
        end
        n_tests++; if (writes !== 10) begin n_fail++; $display("FAIL bp_writes: got %0d need 10", writes); end
        n_tests++; if (fq.size() !== 8) begin n_fail++; $display("FAIL bp_level: got %0d need 8", fq.size()); end
        for (int i = 0; i < 8 && i < fq.size(); i++) begin
            n_tests++; if (fq[i] !== 8'(8'h42 + i)) begin n_fail++; $display("FAIL bp_content%0d: got %h need %h", i, fq[i], 8'(8'h42 + i)); end
        end
        n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL bp_end_busy: got %b need 0", busy); end
        idle_inputs();
    endtask

    task automatic test_random();
        int seq [N];
        int rem [N];
        int m_owner = -1;
        int m_last  = 0;
        int m_prio  = 0;
        int c;
        bit found;
        logic         e_busy;
        logic [1:0]   e_gid;
        logic [N-1:0] e_ready;
        logic         e_wen;
        for (int i = 0; i < N; i++) begin seq[i] = 0; rem[i] = $urandom_range(1, 5); end
        do_reset();
        for (int cyc = 0; cyc < 3000; cyc++) begin
            @(negedge clk);
            if (fq.size() > 0 && $urandom_range(0, 2) == 0) void'(fq.pop_front());
            fifo_full = (fq.size() >= DEPTH);
            for (int i = 0; i < N; i++) begin
                req_valid[i] = ($urandom_range(0, 3) != 0);
                req_data[i*DW +: DW] = 8'((i << 6) | (seq[i] & 63));
                req_last[i] = (rem[i] == 1);
            end
            #1;
            e_busy  = (m_owner >= 0);
            e_gid   = (m_owner >= 0) ? 2'(m_owner) : 2'(m_last);
            e_ready = '0;
            e_wen   = 1'b0;
            if (m_owner >= 0) begin
                if (!fifo_full) e_ready = 4'(1 << m_owner);
                e_wen = req_valid[m_owner] && !fifo_full;
            end
            n_tests++; if (busy !== e_busy) begin n_fail++; $display("FAIL rnd_busy: cycle %0d got %b need %b", cyc, busy, e_busy); end
            n_tests++; if (grant_id !== e_gid) begin n_fail++; $display("FAIL rnd_gid: cycle %0d got %0d need %0d", cyc, grant_id, e_gid); end
            n_tests++; if (req_ready !== e_ready) begin n_fail++; $display("FAIL rnd_ready: cycle %0d got %b need %b", cyc, req_ready, e_ready); end
            n_tests++; if (fifo_w_en !== e_wen) begin n_fail++; $display("FAIL rnd_wen: cycle %0d got %b need %b", cyc, fifo_w_en, e_wen); end
            if (e_wen) begin
                n_tests++; if (fifo_data_in !== req_data[m_owner*DW +: DW]) begin n_fail++; $display("FAIL rnd_data: cycle %0d got %h need %h", cyc, fifo_data_in, req_data[m_owner*DW +: DW]); end
            end
            if (fifo_w_en === 1'b1) fq.push_back(fifo_data_in);
            for (int i = 0; i < N; i++) begin
                if (req_valid[i] && req_ready[i]) begin
                    seq[i]++;
                    rem[i]--;
                    if (rem[i] == 0) rem[i] = $urandom_range(1, 5);
                end
            end
            // packet-level model: pick the next pending requester after the previous owner
            if (m_owner < 0) begin
                found = 0;
                for (int j = 0; j < N; j++) begin
                    c = (m_prio + j) % N;
                    if (!found && req_valid[c]) begin
                        m_owner = c; m_last = c; found = 1;
                    end
                end
            end else if (e_wen && req_last[m_owner]) begin
                m_prio  = (m_owner + 1) % N;
                m_owner = -1;
            end
        end
        idle_inputs();
    endtask

`ifdef FIFO_WR_ARB_STATS_EN
    task automatic test_stats_wrap();
        int k = 0;
        do_reset();
        for (int cyc = 0; cyc < 24; cyc++) begin
            @(negedge clk);
            req_valid = '0; req_last = '0; req_data = '0;
            req_valid[1] = (k < 16); req_last[1] = (k == 15); req_data[15:8] = 8'(k);
            #1;
            if (req_valid[1] && req_ready[1]) k++;
        end
        n_tests++; if (stat_count[16 +: 16] !== 16'd16) begin n_fail++; $display("FAIL stat16: got %0d need 16", stat_count[16 +: 16]); end
        n_tests++; if (stat_count_w4[4 +: 4] !== 4'd0) begin n_fail++; $display("FAIL stat_wrap: got %0d need 0", stat_count_w4[4 +: 4]); end
        n_tests++; if (stat_count_w4[0 +: 4] !== 4'd0) begin n_fail++; $display("FAIL stat_other: got %0d need 0", stat_count_w4[0 +: 4]); end
        idle_inputs();
    endtask
`endif

    initial begin
        rst = 1'b1;
        idle_inputs();
        test_reset();
        test_single();
        test_round_robin();
        test_no_interleave();
        test_full_backpressure();
        test_random();
`ifdef FIFO_WR_ARB_STATS_EN
        test_stats_wrap();
`endif
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
